// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: state encoding and response codes shared by the AXI4-Lite master blocks
package axi_lite_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;
  localparam logic [1:0] OKAY         = 2'b00;
  localparam logic [1:0] SLVERR       = 2'b10;
  localparam logic [1:0] DECERR       = 2'b11;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;
endpackage

// File: rtl/axil_watchdog.sv
// axil_watchdog: per-transaction cycle counter that flags expiry after TIMEOUT enabled cycles
module axil_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + W'(1) : cnt_q;
  // fires on the cycle that would make the count reach TIMEOUT, so the abort lands exactly then
  assign expired = (TIMEOUT != 0) && enable && (cnt_q == W'(TIMEOUT - 1));
  always_ff @(posedge clock)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/axil_single_master.sv
// axil_single_master: one-transaction-at-a-time AXI4-Lite master with watchdog abort
module axil_single_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [1:0]        resp,
  output logic              AWvalid,
  input  logic              AWready,
  output logic [ADDR_W-1:0] AWaddr,
  output logic              Wvalid,
  input  logic              Wready,
  output logic [31:0]       Wdata,
  input  logic              Bvalid,
  output logic              Bready,
  input  logic [1:0]        Bresp,
  output logic              ARvalid,
  input  logic              ARready,
  output logic [ADDR_W-1:0] ARaddr,
  input  logic              Rvalid,
  output logic              Rready,
  input  logic [31:0]       Rdata,
  input  logic [1:0]        Rresp
);
  state_t state_q, state_d;
  logic aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [31:0] w_data_q, w_data_d, rdata_q, rdata_d;
  logic [1:0] resp_q, resp_d;
  logic wd_clear, wd_enable, expired;
  assign wd_clear  = (state_q == S_IDLE) && start;
  assign wd_enable = state_q inside {S_WADDR, S_WRESP, S_RADDR, S_RDATA};
  axil_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (expired)
  );
  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    aw_addr_d  = aw_addr_q;
    ar_addr_d  = ar_addr_q;
    w_data_d   = w_data_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = write ? S_WADDR : S_RADDR;
        aw_valid_d = write;
        w_valid_d  = write;
        ar_valid_d = !write;
        aw_addr_d  = write ? addr : aw_addr_q;
        w_data_d   = write ? wdata : w_data_q;
        ar_addr_d  = write ? ar_addr_q : addr;
      end
      S_WADDR: begin
        // AW and W complete independently; leave only once both have handshaken
        aw_valid_d = aw_valid_q && !AWready;
        w_valid_d  = w_valid_q && !Wready;
        state_d    = (aw_valid_d || w_valid_d) ? S_WADDR : S_WRESP;
      end
      S_WRESP: if (Bvalid) begin
        resp_d  = Bresp;
        state_d = S_DONE;
      end
      S_RADDR: if (ARready) begin
        ar_valid_d = 1'b0;
        state_d    = S_RDATA;
      end
      S_RDATA: if (Rvalid) begin
        rdata_d = Rdata;
        resp_d  = Rresp;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d    = S_IDLE;
        aw_valid_d = 1'b0;
        w_valid_d  = 1'b0;
        ar_valid_d = 1'b0;
      end
    endcase
    if (expired) begin
      state_d    = S_DONE;
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      ar_valid_d = 1'b0;
      resp_d     = RESP_TIMEOUT;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q    <= S_IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
      w_data_q   <= '0;
      rdata_q    <= '0;
      resp_q     <= OKAY;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      aw_addr_q  <= aw_addr_d;
      ar_addr_q  <= ar_addr_d;
      w_data_q   <= w_data_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
    end
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_DONE;
  assign Bready  = state_q == S_WRESP;
  assign Rready  = state_q == S_RDATA;
  assign AWvalid = aw_valid_q;
  assign Wvalid  = w_valid_q;
  assign ARvalid = ar_valid_q;
  assign AWaddr  = aw_addr_q;
  assign ARaddr  = ar_addr_q;
  assign Wdata   = w_data_q;
  assign rdata   = rdata_q;
  assign resp    = resp_q;
endmodule

// File: tb/tb_axil_single_master.sv
// tb_axil_single_master: scoreboard bench with a configurable-latency AXI4-Lite slave
module tb_axil_single_master;
  localparam int AW = 32;
  localparam int TO = 8;
  logic clock = 1'b0;
  logic reset, start, write;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic busy, done;
  logic [31:0] rdata;
  logic [1:0] resp;
  logic AWvalid, AWready, Wvalid, Wready, Bvalid, Bready, ARvalid, ARready, Rvalid, Rready;
  logic [AW-1:0] AWaddr, ARaddr;
  logic [31:0] Wdata, Rdata;
  logic [1:0] Bresp, Rresp;
  always #5 clock = ~clock;
  axil_single_master #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .write(write), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .resp(resp),
    .AWvalid(AWvalid), .AWready(AWready), .AWaddr(AWaddr),
    .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata),
    .Bvalid(Bvalid), .Bready(Bready), .Bresp(Bresp),
    .ARvalid(ARvalid), .ARready(ARready), .ARaddr(ARaddr),
    .Rvalid(Rvalid), .Rready(Rready), .Rdata(Rdata), .Rresp(Rresp)
  );
  typedef struct {
    logic [31:0] rd;
    logic [1:0]  rs;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, exp_done = 0, done_cyc = -1;
  int aw_hi, w_hi, ar_hi, bready_first, aw_dly, w_dly, ar_dly;
  bit hang, no_resp, aw_done, w_done, ar_done;
  logic [AW-1:0] cur_addr;
  logic [31:0] cur_wdata, model_rdata, rd_val;
  logic [1:0] rs_val;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    exp_t e;
    @(negedge clock);
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rdata", rdata, e.rd);
        chk("resp", 32'(resp), 32'(e.rs));
      end
    end
    if (AWvalid) aw_hi++;
    if (Wvalid) w_hi++;
    if (ARvalid) ar_hi++;
    if (Bready && bready_first < 0) bready_first = cyc;
    start   = 1'b0;
    AWready = !hang && cyc >= aw_dly;
    Wready  = !hang && cyc >= w_dly;
    ARready = !hang && cyc >= ar_dly;
    Bvalid  = !no_resp && aw_done && w_done;
    Rvalid  = !no_resp && ar_done;
    Bresp   = rs_val;
    Rresp   = rs_val;
    Rdata   = rd_val;
    if (AWvalid && AWready) begin
      aw_done = 1'b1;
      chk("awaddr", AWaddr, cur_addr);
    end
    if (Wvalid && Wready) begin
      w_done = 1'b1;
      chk("wdata", Wdata, cur_wdata);
    end
    if (ARvalid && ARready) begin
      ar_done = 1'b1;
      chk("araddr", ARaddr, cur_addr);
    end
  endtask
  task automatic arm(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                     input int awd, input int wd, input int ard, input bit hng);
    aw_dly = awd; w_dly = wd; ar_dly = ard; hang = hng;
    aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
    AWready = 1'b0; Wready = 1'b0; ARready = 1'b0; Bvalid = 1'b0; Rvalid = 1'b0;
    start = 1'b1; write = w; addr = a; wdata = d;
    cur_addr = a; cur_wdata = d;
    cyc = 0; done_cyc = -1; aw_hi = 0; w_hi = 0; ar_hi = 0; bready_first = -1;
  endtask
  task automatic run_txn(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input logic [1:0] rs,
                         input int awd, input int wd, input int ard, input bit hng, input bit poke);
    exp_t e;
    int exp_cyc;
    @(negedge clock);
    arm(w, a, d, awd, wd, ard, hng);
    rd_val = rd; rs_val = rs;
    exp_cyc = hng ? TO + 1 : w ? ((awd > wd ? awd : wd) + 2) : ard + 2;
    e.rs = hng ? 2'b11 : rs;
    if (!hng && !w) model_rdata = rd;
    e.rd = model_rdata;
    sb.push_back(e);
    exp_done++;
    for (int i = 0; i < 40 && done_cyc < 0; i++) begin
      step();
      if (poke && cyc == 1) begin
        start = 1'b1; write = 1'b0; addr = 'hDEAD0;
      end
    end
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    chk("done_cycle", done_cyc, exp_cyc);
    step();
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
    chk("valids_low", {29'd0, AWvalid, Wvalid, ARvalid}, 32'd0);
    chk("done_count", done_cnt, exp_done);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    AWready = 1'b0; Wready = 1'b0; ARready = 1'b0; Bvalid = 1'b0; Rvalid = 1'b0;
    Bresp = 2'b00; Rresp = 2'b00; Rdata = '0; rd_val = '0; rs_val = 2'b00;
    hang = 1'b0; no_resp = 1'b0; model_rdata = '0; cur_addr = '0; cur_wdata = '0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; bready_first = -1;
    repeat (3) @(negedge clock);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_valids", {29'd0, AWvalid, Wvalid, ARvalid}, 32'd0);
    chk("rst_readies", {30'd0, Bready, Rready}, 32'd0);
    chk("rst_awaddr", AWaddr, 32'd0);
    chk("rst_araddr", ARaddr, 32'd0);
    chk("rst_wdata", Wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    reset = 1'b0;
    run_txn(1'b1, 'h10, 32'hA5A5A5A5, 32'h0, 2'b00, 1, 1, 1, 1'b0, 1'b0);
    run_txn(1'b0, 'h14, 32'h0, 32'h12345678, 2'b00, 1, 1, 5, 1'b0, 1'b0);
    chk("ar_stable_cycles", ar_hi, 5);
    run_txn(1'b1, 'h18, 32'h0BADBEEF, 32'h0, 2'b10, 4, 1, 1, 1'b0, 1'b0);
    chk("w_high_cycles", w_hi, 1);
    chk("aw_high_cycles", aw_hi, 4);
    chk("wresp_entry", bready_first, 5);
    run_txn(1'b0, 'h20, 32'h0, 32'hCAFEF00D, 2'b11, 1, 1, 1, 1'b0, 1'b1);
    repeat (4) step();
    chk("busy_start_ignored", done_cnt, exp_done);
    chk("still_idle", 32'(busy), 32'd0);
    run_txn(1'b1, 'h24, 32'h55AA55AA, 32'h0, 2'b00, 1, 1, 1, 1'b1, 1'b0);
    chk("timeout_aw_cycles", aw_hi, TO);
    run_txn(1'b0, 'h28, 32'h0, 32'hFFFFFFFF, 2'b00, 1, 1, 1, 1'b1, 1'b0);
    chk("timeout_ar_cycles", ar_hi, TO);
    no_resp = 1'b1;
    @(negedge clock);
    arm(1'b0, 'h30, 32'h0, 1, 1, 1, 1'b0);
    step();
    step();
    chk("in_rdata_rready", 32'(Rready), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rready", 32'(Rready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    model_rdata = '0;
    no_resp = 1'b0;
    repeat (4) step();
    chk("abort_no_done", done_cnt, exp_done);
    run_txn(1'b1, 'h34, 32'h13579BDF, 32'h0, 2'b00, 1, 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_txn(1'($urandom_range(0, 1)), AW'($urandom & 32'hFFC), $urandom, $urandom,
              2'($urandom_range(0, 3)), $urandom_range(1, 3), $urandom_range(1, 3),
              $urandom_range(1, 3), 1'b0, 1'b0);
    end
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_time_limit: got=expired expected=finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/axil_single_master.md
AXIL_SINGLE_MASTER -- requirements
Module: axil_single_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AWaddr/ARaddr/addr width; data fixed at 32 bits, full-word writes only (no strobes).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles per transaction before abort; 0 disables.
REQ-003 SHALL have port clock  in  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port write  in  1  1=write, 0=read; latched with start.
REQ-007 SHALL have port addr  in  ADDR_W  target address; latched with start.
REQ-008 SHALL have port wdata  in  32  write data; latched with start.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  out  32  last read data.
REQ-012 SHALL have port resp  out  2  last Bresp/Rresp, or 2'b11 on timeout.
REQ-013 SHALL have port AWvalid  out  1  / AWready  in  1  / AWaddr  out  ADDR_W  write-address channel.
REQ-014 SHALL have port Wvalid  out  1  / Wready  in  1  / Wdata  out  32  write-data channel.
REQ-015 SHALL have port Bvalid  in  1  / Bready  out  1  / Bresp  in  2  write-response channel.
REQ-016 SHALL have port ARvalid  out  1  / ARready  in  1  / ARaddr  out  ADDR_W  read-address channel.
REQ-017 SHALL have port Rvalid  in  1  / Rready  out  1  / Rdata  in  32  / Rresp  in  2  read-data channel.

Function
REQ-018 SHALL implement states IDLE, WADDR, WRESP, RADDR, RDATA, DONE; any unused encoding SHALL go to IDLE next cycle.
REQ-019 IDLE with start=1 SHALL latch write/addr/wdata and enter WADDR (write) or RADDR (read); start outside IDLE SHALL be ignored.
REQ-020 WADDR SHALL assert AWvalid and Wvalid together; each SHALL drop independently the cycle after its own valid&&ready handshake; exit to WRESP when both done, including both in the same cycle.
REQ-021 WRESP SHALL hold Bready=1; Bvalid=1 SHALL capture Bresp into resp and enter DONE; rdata unchanged by writes.
REQ-022 RADDR SHALL hold ARvalid=1 until ARready, then enter RDATA; RDATA SHALL hold Rready=1; Rvalid=1 SHALL capture Rdata/Rresp and enter DONE.
REQ-023 Valid outputs SHALL be registered and never deasserted before handshake except by timeout or reset; ready-before-valid from slave SHALL be accepted.
REQ-024 Bready/Rready SHALL be state-decoded; Bvalid/Rvalid in other states SHALL be ignored.
REQ-025 DONE SHALL pulse done=1 for exactly one cycle, then IDLE; rdata/resp SHALL hold until next capture.
REQ-026 Latency with slave always ready and responding immediately: start sampled at cycle 0 -> done=1 at cycle 3 for both read and write.
REQ-027 Timeout counter SHALL clear on start, increment each cycle in WADDR/WRESP/RADDR/RDATA; on reaching TIMEOUT (nonzero) all valids/readies SHALL drop, resp=2'b11, enter DONE.

Reset
REQ-028 reset=1 at posedge SHALL force IDLE, all valid/ready/busy/done=0, AWaddr/ARaddr/Wdata/rdata=0, resp=0, counter=0; mid-transaction reset SHALL abort with no done pulse.

Structure
REQ-029 Shared package axi_lite_pkg SHALL hold state encoding and response constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
REQ-030 Timeout counter SHALL be the single sub-module axil_watchdog (clear, enable, expired).

Verification
REQ-031 Write addr=0x10, wdata=0xA5A5A5A5, slave always ready, Bresp=00 same cycle -> done at cycle 3, resp=00, AWaddr=0x10 and Wdata=0xA5A5A5A5 at handshake.
REQ-032 Read addr=0x14, ARready delayed 4 cycles, Rdata=0x12345678, Rresp=00 -> ARvalid held stable 5 cycles, rdata=0x12345678, one done pulse.
REQ-033 Write with Wready 3 cycles before AWready -> Wvalid drops after its handshake, AWvalid held; WRESP entered only after AW handshake.
REQ-034 TIMEOUT=8, slave never ready -> valids drop, done at cycle 9 after start, resp=11.
REQ-035 reset asserted in RDATA -> next cycle IDLE, Rready=0, busy=0, no done; start during busy ignored, no second transaction.
